// File: rtl/iqpayload_ram_reconfig_pkg.sv
// Shared definitions for the reconfigurable issue-queue payload RAM.
//   - fallback values for the build-wide width macros
//   - FSM state encoding, WAKE counter width, default settle time
//   - partition-select width helper
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 2
`endif
`ifndef RAM_CONFIG_DEPTH
`define RAM_CONFIG_DEPTH 32
`endif
`ifndef RAM_CONFIG_INDEX
`define RAM_CONFIG_INDEX 5
`endif
`ifndef RAM_CONFIG_WIDTH
`define RAM_CONFIG_WIDTH 16
`endif
`ifndef NUM_PARTS_IQ
`define NUM_PARTS_IQ 4
`endif

package iqpayload_ram_reconfig_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_WAKE  = 2'd1,
    ST_SCRUB = 2'd2
  } iq_fsm_e;

  localparam int WAKE_CNT_W      = 8;
  localparam int WAKE_CYCLES_DEF = 4;

  // Width of a partition number; kept at least 1 so a single-partition
  // build still has a legal (always-zero) select signal.
  function automatic int part_bits(input int nparts);
    return (nparts > 1) ? $clog2(nparts) : 1;
  endfunction

endpackage

// File: rtl/iqpayload_ram_reconfig_if.sv
// Access bus of the payload RAM.
//   addr_i / data_o            : RPORT read lanes
//   addrWr_i / dataWr_i / we_i : WPORT write lanes
//   issueLaneActive_i          : read-lane enables
//   dispatchLaneActive_i       : write-lane enables
//   iqPartitionActive_i        : partition power mask
//   payloadRamReady_o          : storage usable
// master = requester, slave = the RAM.
interface iqpayload_ram_reconfig_if #(
  parameter int RPORT     = 2,
  parameter int WPORT     = 2,
  parameter int INDEX     = 5,
  parameter int WIDTH     = 16,
  parameter int NUM_PARTS = 4
);
  logic [RPORT-1:0][INDEX-1:0] addr_i;
  logic [RPORT-1:0][WIDTH-1:0] data_o;
  logic [WPORT-1:0][INDEX-1:0] addrWr_i;
  logic [WPORT-1:0][WIDTH-1:0] dataWr_i;
  logic [WPORT-1:0]            we_i;
  logic [RPORT-1:0]            issueLaneActive_i;
  logic [WPORT-1:0]            dispatchLaneActive_i;
  logic [NUM_PARTS-1:0]        iqPartitionActive_i;
  logic                        payloadRamReady_o;

  modport master (
    output addr_i, addrWr_i, dataWr_i, we_i,
           issueLaneActive_i, dispatchLaneActive_i, iqPartitionActive_i,
    input  data_o, payloadRamReady_o
  );

  modport slave (
    input  addr_i, addrWr_i, dataWr_i, we_i,
           issueLaneActive_i, dispatchLaneActive_i, iqPartitionActive_i,
    output data_o, payloadRamReady_o
  );
endinterface

// File: rtl/iqpayload_bank.sv
// One payload partition: ENTRIES x WIDTH storage.
//   clk                     : clock
//   rd_idx_i / rd_data_o    : RPORT combinational read ports (old data on
//                             a same-cycle write)
//   wr_en_i/wr_idx_i/wr_data_i : WPORT write ports, higher lane wins
//   scrub_en_i / scrub_idx_i   : zero-fill port used after power-up
// Storage is intentionally not reset.
module iqpayload_bank #(
  parameter int RPORT   = 2,
  parameter int WPORT   = 2,
  parameter int ENTRIES = 8,
  parameter int EIDX    = 3,
  parameter int WIDTH   = 16
) (
  input  logic                        clk,
  input  logic [RPORT-1:0][EIDX-1:0]  rd_idx_i,
  output logic [RPORT-1:0][WIDTH-1:0] rd_data_o,
  input  logic [WPORT-1:0]            wr_en_i,
  input  logic [WPORT-1:0][EIDX-1:0]  wr_idx_i,
  input  logic [WPORT-1:0][WIDTH-1:0] wr_data_i,
  input  logic                        scrub_en_i,
  input  logic [EIDX-1:0]             scrub_idx_i
);
  logic [WIDTH-1:0] mem_q [ENTRIES];

  for (genvar r = 0; r < RPORT; r++) begin : g_rd
    assign rd_data_o[r] = mem_q[rd_idx_i[r]];
  end

  // Lanes are applied in ascending order so the highest-numbered lane's
  // data survives an address collision.
  always_ff @(posedge clk) begin
    if (scrub_en_i) mem_q[scrub_idx_i] <= '0;
    for (int w = 0; w < WPORT; w++)
      if (wr_en_i[w]) mem_q[wr_idx_i[w]] <= wr_data_i[w];
  end
endmodule

// File: rtl/iqpayload_ram_reconfig.sv
// Partitioned issue-queue payload RAM with per-partition power gating.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : slave side of iqpayload_ram_reconfig_if (read/write lanes,
//           lane enables, partition mask, ready)
// Newly powered partitions are held for WAKE_CYCLES and then zero-filled
// one entry per cycle before the RAM reports ready again.
module iqpayload_ram_reconfig
  import iqpayload_ram_reconfig_pkg::*;
#(
  parameter int RPORT        = `ISSUE_WIDTH,
  parameter int WPORT        = `DISPATCH_WIDTH,
  parameter int DEPTH        = `RAM_CONFIG_DEPTH,
  parameter int INDEX        = `RAM_CONFIG_INDEX,
  parameter int WIDTH        = `RAM_CONFIG_WIDTH,
  parameter int NUM_PARTS    = `NUM_PARTS_IQ,
  parameter int WAKE_CYCLES  = WAKE_CYCLES_DEF,
  parameter int READ_LATENCY = 0
) (
  input logic                     clk,
  input logic                     reset,
  iqpayload_ram_reconfig_if.slave bus
);
  localparam int PBITS   = part_bits(NUM_PARTS);
  localparam int EIDX    = INDEX - $clog2(NUM_PARTS);
  localparam int ENTRIES = DEPTH / NUM_PARTS;
  localparam logic [EIDX-1:0]       LAST_IDX  = EIDX'(ENTRIES - 1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_INIT = WAKE_CNT_W'(WAKE_CYCLES - 1);

  function automatic logic [PBITS-1:0] part_of(input logic [INDEX-1:0] a);
    logic [INDEX-1:0] t;
    t = a >> EIDX;
    return t[PBITS-1:0];
  endfunction

  // ---------------- power-up FSM ----------------
  iq_fsm_e               state_q;
  logic [WAKE_CNT_W-1:0] cnt_q;
  logic [EIDX-1:0]       idx_q;
  logic [NUM_PARTS-1:0]  wake_q, prev_q;
  logic                  ready_q;

  logic [NUM_PARTS-1:0] act, gain, keep, scrub_on;

  assign act  = bus.iqPartitionActive_i;
  assign gain = act & ~prev_q;
  // A partition switched off while pending wake simply drops out.
  assign keep = wake_q & act;
  assign scrub_on = (state_q == ST_SCRUB) ? keep : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SCRUB;
      cnt_q   <= '0;
      idx_q   <= '0;
      wake_q  <= '1;
      prev_q  <= '1;
      ready_q <= 1'b0;
    end else begin
      prev_q <= act;
      if (|gain) begin
        // New partitions restart the settle period from any state; any
        // scrub in flight starts over covering the merged mask.
        state_q <= ST_WAKE;
        cnt_q   <= WAKE_INIT;
        wake_q  <= keep | gain;
        ready_q <= 1'b0;
      end else begin
        case (state_q)
          ST_WAKE: begin
            wake_q <= keep;
            if (cnt_q == '0) begin
              state_q <= ST_SCRUB;
              idx_q   <= '0;
            end else begin
              cnt_q <= cnt_q - WAKE_CNT_W'(1);
            end
          end
          ST_SCRUB: begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_READY;
              wake_q  <= '0;
              ready_q <= 1'b1;
            end else begin
              idx_q  <= idx_q + EIDX'(1);
              wake_q <= keep;
            end
          end
          default: begin
            state_q <= ST_READY;
            wake_q  <= keep;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.payloadRamReady_o = ready_q;

  // ---------------- write lanes ----------------
  logic [WPORT-1:0][PBITS-1:0] wpart;
  logic [WPORT-1:0][EIDX-1:0]  went;
  logic [WPORT-1:0]            lane_wr;

  for (genvar w = 0; w < WPORT; w++) begin : g_wl
    assign wpart[w]   = part_of(bus.addrWr_i[w]);
    assign went[w]    = bus.addrWr_i[w][EIDX-1:0];
    assign lane_wr[w] = bus.we_i[w] & bus.dispatchLaneActive_i[w] &
                        act[wpart[w]] & ready_q & ~scrub_on[wpart[w]];
  end

  // ---------------- read lanes ----------------
  logic [RPORT-1:0][PBITS-1:0] rpart;
  logic [RPORT-1:0][EIDX-1:0]  rent;
  logic [NUM_PARTS-1:0][RPORT-1:0][WIDTH-1:0] bank_rd;
  logic [RPORT-1:0][WIDTH-1:0] rd_gated;

  for (genvar r = 0; r < RPORT; r++) begin : g_rl
    assign rpart[r] = part_of(bus.addr_i[r]);
    assign rent[r]  = bus.addr_i[r][EIDX-1:0];
    assign rd_gated[r] = (bus.issueLaneActive_i[r] && act[rpart[r]] && ready_q)
                       ? bank_rd[rpart[r]][r] : '0;
  end

  // ---------------- partitions ----------------
  for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
    logic [WPORT-1:0] bwe;
    for (genvar w = 0; w < WPORT; w++) begin : g_bwe
      assign bwe[w] = lane_wr[w] && (wpart[w] == PBITS'(p));
    end

    iqpayload_bank #(
      .RPORT   (RPORT),
      .WPORT   (WPORT),
      .ENTRIES (ENTRIES),
      .EIDX    (EIDX),
      .WIDTH   (WIDTH)
    ) u_bank (
      .clk         (clk),
      .rd_idx_i    (rent),
      .rd_data_o   (bank_rd[p]),
      .wr_en_i     (bwe),
      .wr_idx_i    (went),
      .wr_data_i   (bus.dataWr_i),
      .scrub_en_i  (scrub_on[p]),
      .scrub_idx_i (idx_q)
    );
  end

  // ---------------- read output stage ----------------
  // Gating is applied before the optional register, so qualifiers are
  // those of the address cycle.
  if (READ_LATENCY == 0) begin : g_lat0
    assign bus.data_o = rd_gated;
  end else begin : g_lat1
    logic [RPORT-1:0][WIDTH-1:0] rd_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_q <= '0;
      else        rd_q <= rd_gated;
    end
    assign bus.data_o = rd_q;
  end
endmodule

// File: tb/tb_iqpayload_ram_reconfig.sv
// Directed bench: DEPTH=32, NUM_PARTS=4, WIDTH=16, 2R/2W, WAKE_CYCLES=4.
// u_dut0 is combinational-read, u_dut1 registered-read; both see the same
// stimulus.
module tb_iqpayload_ram_reconfig;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0][4:0]  addr, addrWr;
  logic [1:0][15:0] dataWr;
  logic [1:0]       we, issue, disp;
  logic [3:0]       mask;

  iqpayload_ram_reconfig_if #(.RPORT(2), .WPORT(2), .INDEX(5), .WIDTH(16), .NUM_PARTS(4)) b0 ();
  iqpayload_ram_reconfig_if #(.RPORT(2), .WPORT(2), .INDEX(5), .WIDTH(16), .NUM_PARTS(4)) b1 ();

  assign b0.addr_i = addr;               assign b1.addr_i = addr;
  assign b0.addrWr_i = addrWr;           assign b1.addrWr_i = addrWr;
  assign b0.dataWr_i = dataWr;           assign b1.dataWr_i = dataWr;
  assign b0.we_i = we;                   assign b1.we_i = we;
  assign b0.issueLaneActive_i = issue;   assign b1.issueLaneActive_i = issue;
  assign b0.dispatchLaneActive_i = disp; assign b1.dispatchLaneActive_i = disp;
  assign b0.iqPartitionActive_i = mask;  assign b1.iqPartitionActive_i = mask;

  iqpayload_ram_reconfig #(.RPORT(2), .WPORT(2), .DEPTH(32), .INDEX(5), .WIDTH(16),
    .NUM_PARTS(4), .WAKE_CYCLES(4), .READ_LATENCY(0))
    u_dut0 (.clk(clk), .reset(reset), .bus(b0.slave));

  iqpayload_ram_reconfig #(.RPORT(2), .WPORT(2), .DEPTH(32), .INDEX(5), .WIDTH(16),
    .NUM_PARTS(4), .WAKE_CYCLES(4), .READ_LATENCY(1))
    u_dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Cycles (sampled on negedges) that ready stays low, bounded.
  task automatic wait_rdy(output int n);
    n = 0;
    while (!b0.payloadRamReady_o && n < 100) begin
      n++;
      cyc();
    end
  endtask

  task automatic wr1(input logic [4:0] a, input logic [15:0] d);
    addrWr[0] = a; dataWr[0] = d; we = 2'b01;
    cyc();
    we = 2'b00;
  endtask

  task automatic rd(input int port, input logic [4:0] a, output logic [15:0] d);
    addr[port] = a;
    #1;
    d = b0.data_o[port];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] d, or2, or3;
    reset = 1'b0; mask = 4'b0011; addr = '0; addrWr = '0; dataWr = '0;
    we = 2'b00; disp = 2'b11; issue = 2'b11;
    repeat (3) cyc();
    chk("rst_rdy", 32'(b0.payloadRamReady_o), 0);
    chk("rst_data0", 32'(b0.data_o[0]), 0);
    chk("rst_data_lat1", 32'(b1.data_o[0]), 0);

    // reset release: 8-entry partitions -> 8 scrub cycles
    reset = 1'b1;
    wait_rdy(n);
    chk("rst_low_cycles", n, 8);
    chk("rdy_after_rst", 32'(b0.payloadRamReady_o), 1);
    rd(0, 5'd0, d);  chk("rd0_zero", d, 0);
    rd(1, 5'd15, d); chk("rd15_zero", d, 0);
    rd(0, 5'd31, d); chk("rd31_inactive", d, 0);

    // collision on address 5; same-cycle read sees old data
    addrWr[0] = 5'd5; dataWr[0] = 16'h1111;
    addrWr[1] = 5'd5; dataWr[1] = 16'h2222;
    we = 2'b11; addr[0] = 5'd5;
    #1;
    chk("coll_old", 32'(b0.data_o[0]), 0);
    cyc();
    we = 2'b00;
    #1;
    chk("coll_new", 32'(b0.data_o[0]), 32'h2222);

    wr1(5'd3, 16'hABCD);

    // wake partition 2: 4 WAKE + 8 SCRUB
    mask = 4'b0111;
    cyc();
    wait_rdy(n);
    chk("wake_low_cycles", n, 12);
    for (int a = 16; a < 24; a++) begin
      rd(0, 5'(a), d);
      chk("wake_p2_zero", d, 0);
    end
    rd(1, 5'd3, d); chk("wake_keep_a3", d, 32'hABCD);

    // fill partition 2, then power it down (immediate gating, no FSM move)
    for (int a = 16; a < 24; a++) wr1(5'(a), 16'hC000 | 16'(a));
    rd(0, 5'd20, d); chk("p2_written", d, 32'hC014);
    mask = 4'b0011;
    #1;
    chk("deact_gate", 32'(b0.data_o[0]), 0);
    cyc();
    chk("deact_rdy", 32'(b0.payloadRamReady_o), 1);

    // re-wake 2, then add 3 while scrubbing index 3
    mask = 4'b0111;
    cyc();
    repeat (7) cyc();
    mask = 4'b1111;
    wait_rdy(n);
    chk("midscrub_low_cycles", n, 13);
    or2 = '0; or3 = '0;
    for (int a = 16; a < 24; a++) begin rd(0, 5'(a), d); or2 = or2 | d; end
    for (int a = 24; a < 32; a++) begin rd(1, 5'(a), d); or3 = or3 | d; end
    chk("midscrub_p2_zero", or2, 0);
    chk("midscrub_p3_zero", or3, 0);
    rd(0, 5'd3, d); chk("midscrub_keep_a3", d, 32'hABCD);

    // lane gating
    wr1(5'd8, 16'h5555);
    addrWr[0] = 5'd7; dataWr[0] = 16'h0777;
    addrWr[1] = 5'd8; dataWr[1] = 16'h0888;
    we = 2'b11; disp = 2'b01;
    cyc();
    we = 2'b00; disp = 2'b11;
    rd(0, 5'd7, d); chk("gate_lane0_wr", d, 32'h0777);
    rd(1, 5'd8, d); chk("gate_lane1_nowr", d, 32'h5555);
    issue = 2'b01;
    rd(1, 5'd7, d); chk("gate_issue1_off", d, 0);
    issue = 2'b11;
    #1;
    chk("gate_issue1_on", 32'(b0.data_o[1]), 32'h0777);

    // registered read path
    addr[0] = 5'd3;
    addrWr[0] = 5'd9; dataWr[0] = 16'h00FF; we = 2'b01;
    cyc();
    we = 2'b00; addr[0] = 5'd9;
    #1;
    chk("lat1_prev_addr", 32'(b1.data_o[0]), 32'hABCD);
    chk("lat0_now", 32'(b0.data_o[0]), 32'h00FF);
    cyc();
    #1;
    chk("lat1_a9", 32'(b1.data_o[0]), 32'h00FF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/iqpayload_ram_reconfig.md
IQPAYLOAD_RAM_RECONFIG -- requirements
Module: iqpayload_ram_reconfig

Interface
REQ-001 SHALL have parameter RPORT, default `ISSUE_WIDTH: number of read ports.
REQ-002 SHALL have parameter WPORT, default `DISPATCH_WIDTH: number of write ports.
REQ-003 SHALL have parameter DEPTH, default `RAM_CONFIG_DEPTH: total entries, power of two.
REQ-004 SHALL have parameter INDEX, default `RAM_CONFIG_INDEX: address width, log2(DEPTH).
REQ-005 SHALL have parameter WIDTH, default `RAM_CONFIG_WIDTH: payload bits.
REQ-006 SHALL have parameter NUM_PARTS, default `NUM_PARTS_IQ: partitions, power of two, 1..DEPTH/2.
REQ-007 SHALL have parameter WAKE_CYCLES, default 4: power-up settle cycles for a woken partition, 1..255.
REQ-008 SHALL have parameter READ_LATENCY, default 0: read latency, 0 (combinational) or 1 (registered).
REQ-009 SHALL have port clk, input, 1: the single clock.
REQ-010 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-011 SHALL have port addr_i, input, RPORT x INDEX: read addresses.
REQ-012 SHALL have port data_o, output, RPORT x WIDTH: read data.
REQ-013 SHALL have port addrWr_i, input, WPORT x INDEX: write addresses.
REQ-014 SHALL have port dataWr_i, input, WPORT x WIDTH: write data.
REQ-015 SHALL have port we_i, input, WPORT: write enables.
REQ-016 SHALL have port issueLaneActive_i, input, RPORT: read-lane enables.
REQ-017 SHALL have port dispatchLaneActive_i, input, WPORT: write-lane enables.
REQ-018 SHALL have port iqPartitionActive_i, input, NUM_PARTS: partition power mask.
REQ-019 SHALL have port payloadRamReady_o, output, 1: storage usable.

Function
REQ-020 SHALL select the partition from the top log2(NUM_PARTS) address bits and the entry from the remaining bits; with NUM_PARTS=1 all accesses go to partition 0.
REQ-021 SHALL write a lane only when we_i, dispatchLaneActive_i and the target partition's active bit are all 1, payloadRamReady_o is 1, and the FSM is not scrubbing that partition.
REQ-022 SHALL, when two lanes write the same address in one cycle, keep the highest-numbered lane's data.
REQ-023 SHALL return pre-write (old) data on a same-cycle read/write to one address.
REQ-024 SHALL drive data_o[rp] to 0 when issueLaneActive_i[rp]=0 or the addressed partition is inactive or not ready.
REQ-025 SHALL, with READ_LATENCY=1, register data_o one cycle after the address; the gating qualifiers are sampled in the address cycle.
REQ-026 SHALL implement an FSM with states READY, WAKE and SCRUB.
REQ-027 SHALL latch wakeMask = active & ~prevActive whenever the mask gains bits: any state -> WAKE, counter = WAKE_CYCLES-1, wakeMask ORed into any pending mask.
REQ-028 SHALL make WAKE decrement its counter each cycle and go to SCRUB with index 0 when the counter reaches 0.
REQ-029 SHALL make SCRUB write 0 to entry index in every wakeMask partition each cycle, then go to READY after index DEPTH/NUM_PARTS-1, clearing wakeMask.
REQ-030 SHALL gate a partition immediately on deactivation, with no FSM transition; deactivating a partition in wakeMask removes it from wakeMask.
REQ-031 SHALL drive payloadRamReady_o to 1 only in READY; it is registered.

Reset
REQ-032 SHALL, during reset, force state SCRUB, wakeMask all-ones, index 0, payloadRamReady_o 0, data_o 0, and prevActive all-ones; storage is not reset.
REQ-033 SHALL, after reset release, scrub all partitions in DEPTH/NUM_PARTS cycles before payloadRamReady_o rises.

Structure
REQ-034 SHALL place the FSM state enum, the WAKE counter width (8) and the default WAKE_CYCLES in a shared package.
REQ-035 SHALL use one sub-module iqpayload_bank (one partition: RPORT read ports, WPORT write ports plus one scrub port), instantiated NUM_PARTS times.

Verification
Bench parameters: DEPTH=32, NUM_PARTS=4, WIDTH=16, RPORT=WPORT=2, WAKE_CYCLES=4, READ_LATENCY=0 unless stated.
REQ-036 SHALL cover reset release: payloadRamReady_o=0 for exactly 8 cycles, then 1; a read of any address returns 0x0000.
REQ-037 SHALL cover a write collision: lanes 0 and 1 write 0x1111 and 0x2222 to address 5 -> next-cycle read returns 0x2222; a same-cycle read returns old 0x0000.
REQ-038 SHALL cover partition wake: mask 0011->0111 -> ready low 4 WAKE + 8 SCRUB cycles; address 16..23 reads 0; a prior write of 0xABCD to address 3 is preserved.
REQ-039 SHALL cover a wake mid-scrub: mask 0111->1111 at SCRUB index 3 -> FSM restarts WAKE; both partitions 2 and 3 are scrubbed in full.
REQ-040 SHALL cover lane gating: dispatchLaneActive_i=01, we_i=11 -> only lane 0 writes; issueLaneActive_i=01 -> data_o[1]=0.
REQ-041 SHALL cover READ_LATENCY=1: write 0x00FF to address 9, read address 9 -> data_o shows 0x00FF one cycle after the address.
